// File: rtl/traffic_pkg.sv
// Shared lamp encodings and state codes for the two-road junction controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    DARK   = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } lamp_t;

  // Code 3'd7 is deliberately unused; the controller recovers from it to HG.
  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    CG    = 3'd3,
    CY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

endpackage

// File: rtl/traffic_dwell_timer.sv
// Per-state dwell counter: cleared on reset or state change, saturates at
// all-ones, or wraps at wrap_at when wrap_en is set (night flash timing).
module traffic_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clck,
  input  logic             clear,
  input  logic             restart,
  input  logic             wrap_en,
  input  logic [CNT_W-1:0] wrap_at,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clck) begin
    if (clear || restart) begin
      count <= '0;
    end else if (wrap_en && (count == wrap_at)) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_junction_controller.sv
// Highway / country-road junction controller: Moore FSM with counter-based
// dwell timing, all-red clearance phases and a night flashing mode.
module traffic_junction_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int Y2R_CYCLES      = 5,
  parameter int R2G_CYCLES      = 4,
  parameter int MIN_HWY_GREEN   = 8,
  parameter int MAX_CNTRY_GREEN = 16,
  parameter int FLASH_HALF      = 2
) (
  input  logic       clck,
  input  logic       clear,
  input  logic       X,
  input  logic       night,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] state_o
);

  // Timer thresholds are "last cycle of the phase" values, as the timer is 0
  // in the first cycle of every state.
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_HWY_GREEN - 1);
  localparam logic [CNT_W-1:0] Y2R_T   = CNT_W'(Y2R_CYCLES - 1);
  localparam logic [CNT_W-1:0] R2G_T   = CNT_W'(R2G_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAXC_T  = CNT_W'(MAX_CNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] FLASH_T = CNT_W'(FLASH_HALF - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic             flash_phase;
  logic             restart;

  assign restart = (next_state != state);

  traffic_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clck    (clck),
    .clear   (clear),
    .restart (restart),
    .wrap_en (state == FLASH),
    .wrap_at (FLASH_T),
    .count   (timer)
  );

  always_ff @(posedge clck) begin
    if (clear) begin
      state <= HG;
    end else begin
      state <= next_state;
    end
  end

  // Phase restarts at 0 on every state change, so FLASH always opens on phase 0.
  always_ff @(posedge clck) begin
    if (clear || restart) begin
      flash_phase <= 1'b0;
    end else if ((state == FLASH) && (timer == FLASH_T)) begin
      flash_phase <= ~flash_phase;
    end
  end

  always_comb begin
    next_state = state;
    if (night && (state != FLASH)) begin
      next_state = FLASH;
    end else begin
      case (state)
        HG:      if (X && (timer >= MIN_T))      next_state = HY;
        HY:      if (timer == Y2R_T)             next_state = AR1;
        AR1:     if (timer == R2G_T)             next_state = CG;
        CG:      if (!X || (timer == MAXC_T))    next_state = CY;
        CY:      if (timer == Y2R_T)             next_state = AR2;
        AR2:     if (timer == R2G_T)             next_state = HG;
        FLASH:   if (!night)                     next_state = AR2;
        default:                                 next_state = HG;
      endcase
    end
  end

  always_comb begin
    hwy   = RED;
    cntry = RED;
    case (state)
      HG:  hwy   = GREEN;
      HY:  hwy   = YELLOW;
      CG:  cntry = GREEN;
      CY:  cntry = YELLOW;
      FLASH: begin
        if (flash_phase) begin
          hwy   = DARK;
          cntry = DARK;
        end else begin
          hwy   = YELLOW;
        end
      end
      default: begin
        hwy   = RED;
        cntry = RED;
      end
    endcase
  end

  assign state_o = state;

endmodule
